// File: rtl/ysyx_220066_if_fetch_if.sv
// ysyx_220066_if_fetch_if
//   Bundles the fetch unit's three conversations:
//   - IF side: pc in, flush in, if_block out.
//   - imem request/response: imem_req_* out/in, imem_rsp_* in.
//   - ID side: id_valid/id_pc/id_instr/id_fault out, id_ready in.
//   The master modport is the fetch unit; the slave modport is its surroundings
//   (IF stage, instruction memory and ID stage together).
//
//   Handshake rule for both imem_req and id channels: a transfer happens on a
//   rising clk edge where valid & ready are both 1. The producer never makes
//   valid depend on ready. Once valid is high, payload stays constant until the
//   transfer or a flush. imem_rsp has no ready: each response beat is a single
//   cycle of imem_rsp_valid.
interface ysyx_220066_if_fetch_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            if_block;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            imem_rsp_err;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
  logic            id_fault;
  logic            id_ready;

  modport master (
    input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           imem_rsp_err, id_ready,
    output if_block, imem_req_valid, imem_req_addr, id_valid, id_pc,
           id_instr, id_fault
  );

  modport slave (
    output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           imem_rsp_err, id_ready,
    input  if_block, imem_req_valid, imem_req_addr, id_valid, id_pc,
           id_instr, id_fault
  );
endinterface

// File: rtl/ysyx_220066_if_fetch.sv
// ysyx_220066_if_fetch
//   Instruction-fetch request/response unit sitting after the IF pc register.
//   Issues at most one outstanding imem read for the current pc, buffers the
//   returned {pc, instr, fault} in a DEPTH-entry FIFO feeding ID, stalls IF via
//   if_block, and kills in-flight and buffered fetches on flush.
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : ysyx_220066_if_fetch_if.master (IF, imem and ID signals)
//   dbg_state  : current FSM state (0 IDLE, 1 WAIT, 2 DROP)
//   dbg_count  : number of valid FIFO entries
module ysyx_220066_if_fetch #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_220066_if_fetch_if.master   bus,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] mem_pc_q    [DEPTH];
  logic [XLEN-1:0] mem_pc_d    [DEPTH];
  logic [31:0]     mem_instr_q [DEPTH];
  logic [31:0]     mem_instr_d [DEPTH];
  logic            mem_fault_q [DEPTH];
  logic            mem_fault_d [DEPTH];

  logic credit, can_issue, req_valid, mis_push, fire, rsp_push, push, pop;

  always_comb begin
    // Credit uses registered count only, so a same-cycle pop never lets a new
    // fetch start; outstanding request reserves one slot.
    credit    = (cnt_q + CW'(state_q == ST_WAIT)) < CW'(DEPTH);
    can_issue = (state_q == ST_IDLE) & credit & ~bus.flush & ~rst;
    req_valid = can_issue & (bus.pc[1:0] == 2'b00);
    // A misaligned pc never reaches memory; it becomes a fault entry directly
    // and advances IF exactly like an accepted request.
    mis_push  = can_issue & (bus.pc[1:0] != 2'b00);
    fire      = req_valid & bus.imem_req_ready;
    rsp_push  = (state_q == ST_WAIT) & bus.imem_rsp_valid & ~bus.flush;
    push      = rsp_push | mis_push;
    pop       = (cnt_q != '0) & bus.id_ready & ~bus.flush;
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d   = ST_WAIT;
          pend_pc_d = bus.pc;
        end
      end
      ST_WAIT: begin
        // A response arriving with the flush is simply discarded.
        if (bus.imem_rsp_valid) state_d = ST_IDLE;
        else if (bus.flush)     state_d = ST_DROP;
      end
      ST_DROP: begin
        // The killed response retires the outstanding read even when another
        // flush arrives with it; nothing would be left to wait for.
        if (bus.imem_rsp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO next state
  always_comb begin
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    mem_fault_d = mem_fault_q;
    if (bus.flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]    = mis_push ? bus.pc : pend_pc_q;
        mem_instr_d[wr_ptr_q] = mis_push ? 32'h0 : bus.imem_rsp_data;
        mem_fault_d[wr_ptr_q] = mis_push | bus.imem_rsp_err;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_pc_q   <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      mem_pc_q    <= '{default: '0};
      mem_instr_q <= '{default: '0};
      mem_fault_q <= '{default: 1'b0};
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = bus.pc;
    bus.if_block       = rst | ~(bus.flush | fire | mis_push);
    // Head outputs come straight from storage flops selected by a registered
    // pointer, so they hold steady while ID stalls.
    bus.id_valid       = (cnt_q != '0);
    bus.id_pc          = mem_pc_q[rd_ptr_q];
    bus.id_instr       = mem_instr_q[rd_ptr_q];
    bus.id_fault       = mem_fault_q[rd_ptr_q];
    dbg_state          = state_q;
    dbg_count          = cnt_q;
  end
endmodule
